// File: rtl/fetch_pkg.sv
// Shared defaults and redirect-source encoding for the prefetching fetch stage.
package fetch_pkg;

  localparam int unsigned START_ADDR_DEF = 32;
  localparam int unsigned ISR_ADDR_DEF   = 0;
  localparam int unsigned NOP_WORD       = 0;

  typedef enum logic [1:0] {
    RD_NONE,
    RD_BR,
    RD_INT,
    RD_RET
  } redir_src_t;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch queue: synchronous FIFO with flush; push and pop may coincide even when full.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int W     = 16,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         push,
  input  logic [W-1:0]                 push_data,
  input  logic                         pop,
  output logic [W-1:0]                 head,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic          do_push;
  logic          do_pop;

  assign do_pop  = pop && (count != '0);
  assign do_push = push && ((count != CW'(DEPTH)) || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= W'(NOP_WORD);
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fetch_prefetch.sv
// Fetch stage: issues in-order memory requests into a prefetch queue and handles
// branch, interrupt and return-address redirects, discarding stale in-flight words.
module fetch_prefetch
  import fetch_pkg::*;
#(
  parameter int W         = 16,
  parameter int AW        = 32,
  parameter int DEPTH     = 4,
  parameter int MAX_OUT   = 4,
  parameter int RET_WORDS = 2,
  parameter logic [AW-1:0] START_ADDR = AW'(START_ADDR_DEF),
  parameter logic [AW-1:0] ISR_ADDR   = AW'(ISR_ADDR_DEF)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          redir_valid,
  input  logic [AW-1:0] redir_target,
  input  logic          int_req,
  output logic          int_ack,
  input  logic          ret_wr,
  input  logic [W-1:0]  ret_word,
  input  logic          ret_go,
  output logic          imem_req,
  output logic [AW-1:0] imem_addr,
  input  logic          imem_gnt,
  input  logic          imem_rvalid,
  input  logic [W-1:0]  imem_rdata,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  out_instr,
  output logic [AW-1:0] out_pc,
  output logic [AW-1:0] out_pc_1
);

  localparam int OW = $clog2(MAX_OUT+1);
  localparam int CW = $clog2(DEPTH+1);
  localparam int RB = RET_WORDS*W;

  logic          live;
  logic [AW-1:0] fpc;
  logic [AW-1:0] head_pc;
  logic [OW-1:0] outstanding;
  logic [OW-1:0] outstanding_nxt;
  logic [OW-1:0] drop_cnt;
  logic [RB-1:0] ret_buf;
  logic [RB-1:0] ret_buf_nxt;
  logic          ret_pend;
  logic [CW-1:0] q_count;
  logic [W-1:0]  q_head;
  redir_src_t    src;
  logic [AW-1:0] redir_pc;
  logic          redirect;
  logic          fire;
  logic          drop;
  logic          push;
  logic          pop;

  // Returned words enter at the bottom, so the first word popped ends up most significant.
  generate
    if (RET_WORDS > 1) begin : g_ret_shift
      assign ret_buf_nxt = ret_wr ? {ret_buf[RB-W-1:0], ret_word} : ret_buf;
    end else begin : g_ret_single
      assign ret_buf_nxt = ret_wr ? ret_word : ret_buf;
    end
  endgenerate

  always_comb begin
    src      = RD_NONE;
    redir_pc = head_pc;
    if (!live) begin
      src = RD_NONE;
    end else if (redir_valid) begin
      src      = RD_BR;
      redir_pc = redir_target;
    end else if (int_req) begin
      src      = RD_INT;
      redir_pc = ISR_ADDR;
    end else if (ret_pend) begin
      src      = RD_RET;
      redir_pc = ret_buf_nxt[AW-1:0];
    end
  end

  assign redirect  = (src != RD_NONE);
  assign int_ack   = (src == RD_INT);

  assign imem_req  = live && ((int'(q_count) + int'(outstanding)) < DEPTH)
                          && (int'(outstanding) < MAX_OUT);
  assign imem_addr = fpc;
  assign fire      = imem_req && imem_gnt;

  assign drop      = imem_rvalid && (drop_cnt != '0);
  assign push      = imem_rvalid && (drop_cnt == '0) && !redirect;
  assign pop       = out_valid && out_ready && !redirect;

  assign outstanding_nxt = outstanding + OW'(fire) - OW'(imem_rvalid);

  assign out_valid = (q_count != '0);
  assign out_instr = out_valid ? q_head : W'(NOP_WORD);
  assign out_pc    = head_pc;
  assign out_pc_1  = head_pc + AW'(1);

  fetch_fifo #(
    .W     (W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect),
    .push      (push),
    .push_data (imem_rdata),
    .pop       (pop),
    .head      (q_head),
    .count     (q_count)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      live        <= 1'b0;
      fpc         <= START_ADDR;
      head_pc     <= START_ADDR;
      outstanding <= '0;
      drop_cnt    <= '0;
      ret_buf     <= '0;
      ret_pend    <= 1'b0;
    end else begin
      live        <= 1'b1;
      outstanding <= outstanding_nxt;
      ret_buf     <= ret_buf_nxt;

      if (ret_go)             ret_pend <= 1'b1;
      else if (src == RD_RET) ret_pend <= 1'b0;

      // After a redirect every word still in flight belongs to the old stream.
      if (redirect) begin
        fpc      <= redir_pc;
        head_pc  <= redir_pc;
        drop_cnt <= outstanding_nxt;
      end else begin
        if (fire) fpc     <= fpc + AW'(1);
        if (pop)  head_pc <= head_pc + AW'(1);
        if (drop) drop_cnt <= drop_cnt - OW'(1);
      end
    end
  end

endmodule
